// File: rtl/alu_pkg.sv
// Shared constants for the ALU and its issue unit: control codes, RV32I opcodes, widths.
package alu_pkg;

  localparam int REG_DATA_WIDTH = 32;
  localparam int CTRL_WIDTH     = 4;

  localparam logic [CTRL_WIDTH-1:0] ALU_ADD  = 4'b0000;
  localparam logic [CTRL_WIDTH-1:0] ALU_SLL  = 4'b0001;
  localparam logic [CTRL_WIDTH-1:0] ALU_SLT  = 4'b0010;
  localparam logic [CTRL_WIDTH-1:0] ALU_SLTU = 4'b0011;
  localparam logic [CTRL_WIDTH-1:0] ALU_XOR  = 4'b0100;
  localparam logic [CTRL_WIDTH-1:0] ALU_SRL  = 4'b0101;
  localparam logic [CTRL_WIDTH-1:0] ALU_OR   = 4'b0110;
  localparam logic [CTRL_WIDTH-1:0] ALU_AND  = 4'b0111;
  localparam logic [CTRL_WIDTH-1:0] ALU_SUB  = 4'b1000;
  localparam logic [CTRL_WIDTH-1:0] ALU_SRA  = 4'b1101;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  function automatic logic is_shift(input logic [CTRL_WIDTH-1:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Input and output valid/ready channels of the ALU issue unit.
interface alu_issue_if;

  logic                                in_valid;
  logic                                in_ready;
  logic [31:0]                         in_instr;
  logic [alu_pkg::REG_DATA_WIDTH-1:0]  in_pc;
  logic [alu_pkg::REG_DATA_WIDTH-1:0]  in_rs1;
  logic [alu_pkg::REG_DATA_WIDTH-1:0]  in_rs2;
  logic                                out_valid;
  logic                                out_ready;
  logic [4:0]                          out_rd;
  logic [alu_pkg::REG_DATA_WIDTH-1:0]  out_result;
  logic                                out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, in_rs1, in_rs2, out_ready,
    input  in_ready, out_valid, out_rd, out_result, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, in_rs1, in_rs2, out_ready,
    output in_ready, out_valid, out_rd, out_result, out_illegal
  );

endinterface

// File: rtl/ALU.sv
// Combinational RV32I integer ALU driven by a 4-bit control code.
module ALU
  import alu_pkg::*;
(
  input  logic [REG_DATA_WIDTH-1:0] din_0,
  input  logic [REG_DATA_WIDTH-1:0] din_1,
  input  logic [CTRL_WIDTH-1:0]     ctrl,
  output logic [REG_DATA_WIDTH-1:0] result
);

  // Operation select
  always_comb begin
    result = '0;
    case (ctrl)
      ALU_ADD:  result = din_0 + din_1;
      ALU_SUB:  result = din_0 - din_1;
      ALU_SLL:  result = din_0 << din_1[4:0];
      ALU_SLT:  result = {{(REG_DATA_WIDTH-1){1'b0}}, ($signed(din_0) < $signed(din_1))};
      ALU_SLTU: result = {{(REG_DATA_WIDTH-1){1'b0}}, (din_0 < din_1)};
      ALU_XOR:  result = din_0 ^ din_1;
      ALU_SRL:  result = din_0 >> din_1[4:0];
      ALU_SRA:  result = $unsigned($signed(din_0) >>> din_1[4:0]);
      ALU_OR:   result = din_0 | din_1;
      ALU_AND:  result = din_0 & din_1;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// Execute-stage issue unit: decodes OP/OP-IMM/LUI/AUIPC, registers the ALU inputs (S1)
// and the ALU result (S2), with valid/ready handshakes on both sides.
module alu_issue
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  alu_issue_if.slave  bus
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [REG_DATA_WIDTH-1:0] imm_i, imm_u;

  assign opcode = bus.in_instr[6:0];
  assign funct3 = bus.in_instr[14:12];
  assign funct7 = bus.in_instr[31:25];
  assign imm_i  = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
  assign imm_u  = {bus.in_instr[31:12], 12'h000};

  logic [CTRL_WIDTH-1:0]     dec_ctrl;
  logic [REG_DATA_WIDTH-1:0] dec_din0, dec_din1;
  logic                      dec_illegal;

  // Instruction decode into ALU control and operand pair
  always_comb begin
    dec_ctrl    = ALU_ADD;
    dec_din0    = '0;
    dec_din1    = '0;
    dec_illegal = 1'b1;
    case (opcode)
      OPC_OP: begin
        dec_din0 = bus.in_rs1;
        dec_din1 = bus.in_rs2;
        dec_ctrl = {funct7[5], funct3};
        if ((funct7 == 7'b0000000) ||
            ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)))) begin
          dec_illegal = 1'b0;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec_din0 = bus.in_rs1;
        dec_din1 = imm_i;
        if (funct3 == 3'b101) begin
          dec_ctrl    = bus.in_instr[30] ? ALU_SRA : ALU_SRL;
          dec_illegal = !((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
        end else if (funct3 == 3'b001) begin
          dec_ctrl    = ALU_SLL;
          dec_illegal = (funct7 != 7'b0000000);
        end else begin
          dec_ctrl    = {1'b0, funct3};
          dec_illegal = 1'b0;
        end
      end
      OPC_LUI: begin
        dec_din1    = imm_u;
        dec_illegal = 1'b0;
      end
      OPC_AUIPC: begin
        dec_din0    = bus.in_pc;
        dec_din1    = imm_u;
        dec_illegal = 1'b0;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
    // Illegal forms reach the ALU as ADD 0+0; shift amounts never exceed 31
    if (dec_illegal) begin
      dec_ctrl = ALU_ADD;
      dec_din0 = '0;
      dec_din1 = '0;
    end else if (is_shift(dec_ctrl)) begin
      dec_din1 = {27'b0, dec_din1[4:0]};
    end else begin
      dec_din1 = dec_din1;
    end
  end

  logic                      v1_q, v1_d;
  logic [CTRL_WIDTH-1:0]     ctrl_q, ctrl_d;
  logic [REG_DATA_WIDTH-1:0] din0_q, din0_d, din1_q, din1_d;
  logic [4:0]                rd1_q, rd1_d;
  logic                      ill1_q, ill1_d;
  logic                      ov_q, ov_d;
  logic [REG_DATA_WIDTH-1:0] res_q, res_d;
  logic [4:0]                ord_q, ord_d;
  logic                      oill_q, oill_d;
  logic [REG_DATA_WIDTH-1:0] alu_result;
  logic                      adv2, in_ready_s;

  ALU u_alu (
    .din_0  (din0_q),
    .din_1  (din1_q),
    .ctrl   (ctrl_q),
    .result (alu_result)
  );

  assign adv2       = !ov_q || bus.out_ready;
  assign in_ready_s = !reset && (!v1_q || adv2);

  // Next state of the issue (S1) and output (S2) stages
  always_comb begin
    v1_d   = v1_q;
    ctrl_d = ctrl_q;
    din0_d = din0_q;
    din1_d = din1_q;
    rd1_d  = rd1_q;
    ill1_d = ill1_q;
    ov_d   = ov_q;
    res_d  = res_q;
    ord_d  = ord_q;
    oill_d = oill_q;
    if (in_ready_s) begin
      v1_d = bus.in_valid;
      if (bus.in_valid) begin
        ctrl_d = dec_ctrl;
        din0_d = dec_din0;
        din1_d = dec_din1;
        rd1_d  = bus.in_instr[11:7];
        ill1_d = dec_illegal;
      end else begin
        ctrl_d = ctrl_q;
      end
    end else begin
      v1_d = v1_q;
    end
    if (adv2) begin
      ov_d = v1_q;
      if (v1_q) begin
        res_d  = ill1_q ? '0 : alu_result;
        ord_d  = rd1_q;
        oill_d = ill1_q;
      end else begin
        res_d = res_q;
      end
    end else begin
      ov_d = ov_q;
    end
  end

  // Stage registers with synchronous flush
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q   <= 1'b0;
      ctrl_q <= ALU_ADD;
      din0_q <= '0;
      din1_q <= '0;
      rd1_q  <= 5'd0;
      ill1_q <= 1'b0;
      ov_q   <= 1'b0;
      res_q  <= '0;
      ord_q  <= 5'd0;
      oill_q <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      ctrl_q <= ctrl_d;
      din0_q <= din0_d;
      din1_q <= din1_d;
      rd1_q  <= rd1_d;
      ill1_q <= ill1_d;
      ov_q   <= ov_d;
      res_q  <= res_d;
      ord_q  <= ord_d;
      oill_q <= oill_d;
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = ov_q;
  assign bus.out_result  = res_q;
  assign bus.out_rd      = ord_q;
  assign bus.out_illegal = oill_q;

endmodule

// File: tb/tb_alu_issue.sv
// Randomized and directed bench for alu_issue, checked against an instruction-level model.
module tb_alu_issue;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_issue_if bus();

  alu_issue dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_res;
  logic [4:0]  prev_rd;
  logic        prev_ill;
  logic        obs_ov;
  logic [31:0] last_res;
  logic [4:0]  last_rd;
  logic        last_ill;
  logic        saw_block;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Instruction-level semantics of the issue unit + ALU
  function automatic exp_t model(input logic [31:0] instr, pc, rs1, rs2);
    exp_t e;
    logic [6:0] opc = instr[6:0];
    logic [2:0] f3 = instr[14:12];
    logic [6:0] f7 = instr[31:25];
    logic [31:0] imm = {{20{instr[31]}}, instr[31:20]};
    logic [31:0] u = {instr[31:12], 12'h000};
    logic signed [31:0] s1 = rs1;
    e.rd = instr[11:7];
    e.ill = 1'b0;
    e.res = 32'h0;
    if (opc == 7'b0110011) begin
      if (f7 == 7'h00) begin
        case (f3)
          3'd0: e.res = rs1 + rs2;
          3'd1: e.res = rs1 << rs2[4:0];
          3'd2: e.res = ($signed(rs1) < $signed(rs2)) ? 32'd1 : 32'd0;
          3'd3: e.res = (rs1 < rs2) ? 32'd1 : 32'd0;
          3'd4: e.res = rs1 ^ rs2;
          3'd5: e.res = rs1 >> rs2[4:0];
          3'd6: e.res = rs1 | rs2;
          default: e.res = rs1 & rs2;
        endcase
      end else if (f7 == 7'h20 && f3 == 3'd0) e.res = rs1 - rs2;
      else if (f7 == 7'h20 && f3 == 3'd5) e.res = s1 >>> rs2[4:0];
      else e.ill = 1'b1;
    end else if (opc == 7'b0010011) begin
      case (f3)
        3'd0: e.res = rs1 + imm;
        3'd1: if (f7 == 7'h00) e.res = rs1 << imm[4:0]; else e.ill = 1'b1;
        3'd2: e.res = ($signed(rs1) < $signed(imm)) ? 32'd1 : 32'd0;
        3'd3: e.res = (rs1 < imm) ? 32'd1 : 32'd0;
        3'd4: e.res = rs1 ^ imm;
        3'd5: if (f7 == 7'h00) e.res = rs1 >> imm[4:0];
              else if (f7 == 7'h20) e.res = s1 >>> imm[4:0];
              else e.ill = 1'b1;
        3'd6: e.res = rs1 | imm;
        default: e.res = rs1 & imm;
      endcase
    end else if (opc == 7'b0110111) e.res = u;
    else if (opc == 7'b0010111) e.res = pc + u;
    else e.ill = 1'b1;
    if (e.ill) e.res = 32'h0;
    return e;
  endfunction

  task automatic step(input logic iv, input logic [31:0] instr, pc, rs1, rs2,
                      input logic ordy, output logic acc);
    exp_t e;
    @(negedge clk);
    bus.in_valid = iv; bus.in_instr = instr; bus.in_pc = pc;
    bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.out_ready = ordy;
    #1;
    obs_ov = bus.out_valid;
    if (prev_stall) begin
      check_val("stall_valid", {31'b0, bus.out_valid}, 32'd1);
      check_val("stall_result", bus.out_result, prev_res);
      check_val("stall_rd", {27'b0, bus.out_rd}, {27'b0, prev_rd});
      check_val("stall_illegal", {31'b0, bus.out_illegal}, {31'b0, prev_ill});
    end
    if (bus.out_valid && ordy) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_out", {31'b0, bus.out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("result", bus.out_result, e.res);
        check_val("rd", {27'b0, bus.out_rd}, {27'b0, e.rd});
        check_val("illegal", {31'b0, bus.out_illegal}, {31'b0, e.ill});
        last_res = bus.out_result; last_rd = bus.out_rd; last_ill = bus.out_illegal;
      end
    end
    acc = iv && bus.in_ready;
    if (iv && !bus.in_ready) saw_block = 1'b1;
    if (acc) exp_q.push_back(model(instr, pc, rs1, rs2));
    prev_stall = bus.out_valid && !ordy;
    prev_res = bus.out_result; prev_rd = bus.out_rd; prev_ill = bus.out_illegal;
  endtask

  task automatic issue(input logic [31:0] instr, pc, rs1, rs2);
    logic acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) step(1'b1, instr, pc, rs1, rs2, 1'b1, acc);
    check_val("issue_accept", {31'b0, acc}, 32'd1);
  endtask

  task automatic drain();
    logic acc;
    for (int t = 0; t < 20 && exp_q.size() > 0; t++) step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, acc);
    check_val("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 9);
    int f = $urandom_range(0, 3);
    if (k < 3) w[6:0] = OPC_OP;
    else if (k < 6) w[6:0] = OPC_OP_IMM;
    else if (k == 6) w[6:0] = OPC_LUI;
    else if (k == 7) w[6:0] = OPC_AUIPC;
    else w[6:0] = w[6:0];
    if (f == 0) w[31:25] = 7'h00;
    else if (f == 1) w[31:25] = 7'h20;
    else w[31:25] = w[31:25];
    return w;
  endfunction

  initial begin
    logic acc;
    logic have;
    logic [31:0] ri, rp, r1, r2;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_instr = 32'h0; bus.in_pc = 32'h0;
    bus.in_rs1 = 32'h0; bus.in_rs2 = 32'h0; bus.out_ready = 1'b1;
    saw_block = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    check_val("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check_val("rst_out_result", bus.out_result, 32'h0);
    check_val("rst_out_rd", {27'b0, bus.out_rd}, 32'd0);
    check_val("rst_out_illegal", {31'b0, bus.out_illegal}, 32'd0);
    check_val("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    reset = 1'b0; #1;
    check_val("in_ready_after_rst", {31'b0, bus.in_ready}, 32'd1);

    // addi x5,x1,1 with two-cycle latency
    step(1'b1, 32'h00108293, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b1, acc);
    check_val("addi_accept", {31'b0, acc}, 32'd1);
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, acc);
    check_val("lat_cycle1_valid", {31'b0, obs_ov}, 32'd0);
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, acc);
    check_val("lat_cycle2_valid", {31'b0, obs_ov}, 32'd1);
    check_val("addi_res", last_res, 32'h00000000);
    check_val("addi_rd", {27'b0, last_rd}, 32'd5);

    issue(32'h40208333, 32'h0, 32'h80000000, 32'h00000021); drain();
    check_val("sub_res", last_res, 32'h7FFFFFDF);
    issue(32'h4020D333, 32'h0, 32'h80000000, 32'h00000021); drain();
    check_val("sra_res", last_res, 32'hC0000000);
    issue(32'h123451B7, 32'h0, 32'h0, 32'h0); drain();
    check_val("lui_res", last_res, 32'h12345000);
    issue(32'h00001217, 32'h00000100, 32'h0, 32'h0); drain();
    check_val("auipc_res", last_res, 32'h00001100);
    issue(32'h4020F333, 32'h0, 32'h1234, 32'h5678); drain();
    check_val("ill_op_flag", {31'b0, last_ill}, 32'd1);
    check_val("ill_op_res", last_res, 32'h0);
    issue(32'h0000057F, 32'h0, 32'h1234, 32'h5678); drain();
    check_val("ill_opc_flag", {31'b0, last_ill}, 32'd1);
    check_val("ill_opc_res", last_res, 32'h0);

    // Four back-to-back ADDIs with three stalled cycles
    saw_block = 1'b0;
    for (int i = 0; i < 4; i++) begin
      acc = 1'b0;
      for (int t = 0; t < 10 && !acc; t++)
        step(1'b1, 32'h00108013 | (32'(i + 1) << 7), 32'h0, 32'(i * 100), 32'h0,
             (i == 0 && t == 0) ? 1'b0 : (i >= 3 || t > 0) ? 1'b1 : 1'b0, acc);
    end
    drain();
    check_val("bp_in_ready_dropped", {31'b0, saw_block}, 32'd1);

    // Reset while two instructions are in flight
    issue(32'h00108293, 32'h0, 32'h5, 32'h0);
    issue(32'h00208313, 32'h0, 32'h7, 32'h0);
    @(negedge clk);
    reset = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1; #1;
    check_val("midrst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    @(negedge clk); #1;
    check_val("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    reset = 1'b0; exp_q.delete(); prev_stall = 1'b0; #1;
    check_val("midrst_ready_after", {31'b0, bus.in_ready}, 32'd1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, acc);

    // Randomized traffic with random backpressure
    have = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!have) begin
        ri = rand_instr(); rp = $urandom; r1 = $urandom; r2 = $urandom; have = 1'b1;
        if ($urandom_range(0, 3) == 0) r2 = 32'($urandom_range(0, 40));
      end
      step(($urandom_range(0, 3) != 0), ri, rp, r1, r2, ($urandom_range(0, 3) != 0), acc);
      if (acc) have = 1'b0;
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
